// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive path and the future uart_tx status reporter.
//   - Command byte constants recognised by the host-terminal control interface.
//   - Receiver FSM state encoding.
package uart_pkg;

   localparam logic [7:0] CMD_RESET   = 8'h72;  // 'r'
   localparam logic [7:0] CMD_PLUS_1  = 8'h75;  // 'u'
   localparam logic [7:0] CMD_PLUS_5  = 8'h55;  // 'U'
   localparam logic [7:0] CMD_MINUS_1 = 8'h64;  // 'd'
   localparam logic [7:0] CMD_MINUS_5 = 8'h44;  // 'D'

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with a 2-flop input synchronizer.
// Ports:
//   i_clk        system clock
//   i_reset_n    asynchronous active-low reset
//   i_uart_rx    serial line, asynchronous to i_clk, idle high
//   o_data       last correctly framed byte (registered)
//   o_valid      one-cycle pulse, o_data updated
//   o_frame_err  one-cycle pulse, stop bit sampled low
//   o_good_stop  combinational strobe in the mid-stop sample cycle of a good frame
//   o_shift      shift register contents (complete byte while o_good_stop is high)
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 10
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_uart_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_good_stop,
   output logic [7:0] o_shift
);

   localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
   localparam logic [TimerW-1:0] HalfBit = TimerW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TimerW-1:0] FullBit = TimerW'(CLKS_PER_BIT - 1);

   logic              rx_meta_q, rx_s;
   rx_state_e         state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        data_q;
   logic              valid_q, frame_err_q;
   logic              good_stop, bad_stop;

   // Synchronizer presets to 1 so reset looks like an idle line.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rx_meta_q <= 1'b1;
         rx_s      <= 1'b1;
      end else begin
         rx_meta_q <= i_uart_rx;
         rx_s      <= rx_meta_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      good_stop = 1'b0;
      bad_stop  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!rx_s) begin
               state_d = StStart;
               timer_d = '0;
            end
         end
         StStart: begin
            if (timer_q == HalfBit) begin
               if (rx_s) begin
                  state_d = StIdle;  // glitch shorter than half a bit
               end else begin
                  state_d   = StData;
                  bit_idx_d = '0;
                  timer_d   = '0;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StData: begin
            if (timer_q == FullBit) begin
               timer_d          = '0;
               shift_d[bit_idx_q] = rx_s;
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StStop: begin
            if (timer_q == FullBit) begin
               timer_d = '0;
               if (rx_s) begin
                  good_stop = 1'b1;
                  state_d   = StIdle;
               end else begin
                  bad_stop = 1'b1;
                  state_d  = StBreak;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StBreak: begin
            // Hold here while the line stays low so a break yields one error only.
            if (rx_s) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= StIdle;
         timer_q     <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         valid_q     <= good_stop;
         frame_err_q <= bad_stop;
         if (good_stop) begin
            data_q <= shift_q;
         end
      end
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_frame_err = frame_err_q;
   assign o_good_stop = good_stop;
   assign o_shift     = shift_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: UART receiver plus single-byte command decoder for the metronome.
// Ports:
//   i_clk, i_reset_n   clock and asynchronous active-low reset
//   i_uart_rx          serial line, idle high
//   o_data, o_valid    last received byte and its one-cycle update pulse
//   o_frame_err        one-cycle pulse on a low stop bit
//   o_cmd_*            one-cycle command pulses, aligned with o_valid
module uart_cmd_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 50_000_000,
   parameter int unsigned BAUD        = 115200
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_uart_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_cmd_reset,
   output logic       o_cmd_plus_1,
   output logic       o_cmd_plus_5,
   output logic       o_cmd_minus_1,
   output logic       o_cmd_minus_5
);

   // Must be >= 8 so the half-bit sample point is well defined.
   localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

   logic       good_stop;
   logic [7:0] shift;
   logic [4:0] cmd_d, cmd_q;  // {reset, plus_1, plus_5, minus_1, minus_5}

   uart_rx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_core (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_uart_rx   (i_uart_rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .o_frame_err (o_frame_err),
      .o_good_stop (good_stop),
      .o_shift     (shift)
   );

   // Decode the completed byte in the good-stop cycle so the pulse lands with o_valid.
   always_comb begin
      cmd_d = '0;
      if (good_stop) begin
         case (shift)
            CMD_RESET:   cmd_d = 5'b10000;
            CMD_PLUS_1:  cmd_d = 5'b01000;
            CMD_PLUS_5:  cmd_d = 5'b00100;
            CMD_MINUS_1: cmd_d = 5'b00010;
            CMD_MINUS_5: cmd_d = 5'b00001;
            default:     cmd_d = '0;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cmd_q <= '0;
      end else begin
         cmd_q <= cmd_d;
      end
   end

   assign o_cmd_reset   = cmd_q[4];
   assign o_cmd_plus_1  = cmd_q[3];
   assign o_cmd_plus_5  = cmd_q[2];
   assign o_cmd_minus_1 = cmd_q[1];
   assign o_cmd_minus_5 = cmd_q[0];

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: scoreboard bench for uart_cmd_rx at 10 clocks per bit.
// Expected events are queued as each frame starts and popped whenever the DUT pulses any output.
module tb_uart_cmd_rx;

   localparam int unsigned CLK_FREQ_HZ = 1_000_000;
   localparam int unsigned BAUD        = 100_000;
   localparam int unsigned BIT_CLKS    = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] data;
   logic       valid, frame_err;
   logic       cmd_reset, cmd_plus_1, cmd_plus_5, cmd_minus_1, cmd_minus_5;
   logic [4:0] cmd;

   assign cmd = {cmd_reset, cmd_plus_1, cmd_plus_5, cmd_minus_1, cmd_minus_5};

   uart_cmd_rx #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .BAUD        (BAUD)
   ) dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_uart_rx     (rx),
      .o_data        (data),
      .o_valid       (valid),
      .o_frame_err   (frame_err),
      .o_cmd_reset   (cmd_reset),
      .o_cmd_plus_1  (cmd_plus_1),
      .o_cmd_plus_5  (cmd_plus_5),
      .o_cmd_minus_1 (cmd_minus_1),
      .o_cmd_minus_5 (cmd_minus_5)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       ferr;
      logic [7:0] data;
      logic [4:0] cmd;
   } exp_t;

   exp_t       sb_q[$];
   int         checks   = 0;
   int         failures = 0;
   logic [7:0] last_data = 8'h00;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] cmd_of(input logic [7:0] b);
      case (b)
         8'h72:   return 5'b10000;
         8'h75:   return 5'b01000;
         8'h55:   return 5'b00100;
         8'h64:   return 5'b00010;
         8'h44:   return 5'b00001;
         default: return 5'b00000;
      endcase
   endfunction

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_byte(input logic [7:0] b);
      exp_t e;
      e.ferr = 1'b0;
      e.data = b;
      e.cmd  = cmd_of(b);
      sb_q.push_back(e);
      last_data = b;
   endtask

   task automatic expect_ferr();
      exp_t e;
      e.ferr = 1'b1;
      e.data = last_data;
      e.cmd  = 5'b00000;
      sb_q.push_back(e);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_clks(BIT_CLKS);
      end
      rx = stop;
      wait_clks(BIT_CLKS);
      rx = 1'b1;
   endtask

   // Every output pulse must match the next queued event; a stretched pulse pops twice.
   always @(negedge clk) begin
      if (rst_n && (valid || frame_err || (|cmd))) begin
         if (sb_q.size() == 0) begin
            check_eq("unexpected_pulse", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("valid", 32'(valid), 32'(!e.ferr));
            check_eq("frame_err", 32'(frame_err), 32'(e.ferr));
            check_eq("data", 32'(data), 32'(e.data));
            check_eq("cmd", 32'(cmd), 32'(e.cmd));
         end
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rx    = 1'b1;
      rst_n = 1'b0;
      wait_clks(4);
      check_eq("rst_data", 32'(data), 32'h00);
      check_eq("rst_valid", 32'(valid), 32'd0);
      check_eq("rst_frame_err", 32'(frame_err), 32'd0);
      check_eq("rst_cmd", 32'(cmd), 32'd0);
      rst_n = 1'b1;
      wait_clks(20);

      // Single plus-1 command
      expect_byte(8'h75);
      send_frame(8'h75, 1'b1);
      wait_clks(20);

      // Zero-gap stream
      expect_byte(8'h55);
      send_frame(8'h55, 1'b1);
      expect_byte(8'h44);
      send_frame(8'h44, 1'b1);
      expect_byte(8'h64);
      send_frame(8'h64, 1'b1);
      expect_byte(8'h72);
      send_frame(8'h72, 1'b1);
      wait_clks(20);

      // Unrecognised byte
      expect_byte(8'h41);
      send_frame(8'h41, 1'b1);
      wait_clks(20);

      // Short low glitch must be ignored
      rx = 1'b0;
      wait_clks(3);
      rx = 1'b1;
      wait_clks(30);
      check_eq("glitch_no_event", 32'(sb_q.size()), 32'd0);
      expect_byte(8'h64);
      send_frame(8'h64, 1'b1);
      wait_clks(20);

      // Framing error followed by held-low line: a single error only
      expect_ferr();
      send_frame(8'h55, 1'b0);
      rx = 1'b0;
      wait_clks(40);
      rx = 1'b1;
      wait_clks(BIT_CLKS);
      check_eq("ferr_data_kept", 32'(data), 32'h64);
      expect_byte(8'h72);
      send_frame(8'h72, 1'b1);
      wait_clks(20);

      // Reset in the middle of a frame discards it
      rx = 1'b0;
      wait_clks(BIT_CLKS);
      rx = 1'b1;
      wait_clks(BIT_CLKS);
      rx = 1'b0;
      wait_clks(BIT_CLKS);
      rx = 1'b1;
      wait_clks(4);
      rst_n = 1'b0;
      wait_clks(3);
      rst_n = 1'b1;
      wait_clks(BIT_CLKS * 12);
      check_eq("abort_data_cleared", 32'(data), 32'h00);
      check_eq("abort_no_event", 32'(sb_q.size()), 32'd0);
      expect_byte(8'h44);
      send_frame(8'h44, 1'b1);
      wait_clks(30);

      check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
